alu_cmd_ctrl: RTL and testbench

Command-side controller for the 8-bit ALU datapath. It accepts operation requests over a valid/ready command interface, drives the ALU operand and control inputs from registers, and captures the ALU result and flags. It returns them over a valid/ready response interface and keeps an accumulator for chained operations. It sits between the instruction/command source and the combinational ALU: it is the initiator, and the ALU is the responder.

---
 rtl/alu_cmd_ctrl.sv | 100 ++++++++++
 tb/tb_alu_cmd_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// Command-side controller for the 8-bit ALU: registers operands/opcode, waits one
// execute cycle, captures result and flags into a held response, keeps an accumulator.
module alu_cmd_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [7:0] alu_y,
  input  logic       alu_zero,
  input  logic       alu_negative,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_y,
  output logic       rsp_zero,
  output logic       rsp_negative,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic [7:0] acc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   op_legal;
  logic   accept;

  always_comb begin
    op_legal = 1'b0;
    case (cmd_op)
      3'b000, 3'b001, 3'b010, 3'b110: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  end

  // Ready is masked by rst_n so it reads 0 for the whole reset window.
  assign cmd_ready = (state == IDLE) && rst_n;
  assign accept    = (state == IDLE) && cmd_valid;
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = op_legal ? EXEC : RESP;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= '0;
      rsp_y        <= '0;
      rsp_zero     <= 1'b0;
      rsp_negative <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_err      <= 1'b0;
      acc          <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (op_legal) begin
          alu_a    <= cmd_use_acc ? acc : cmd_a;
          alu_b    <= cmd_b;
          alu_ctrl <= cmd_op;
        end else begin
          rsp_y        <= '0;
          rsp_zero     <= 1'b0;
          rsp_negative <= 1'b0;
          rsp_carry    <= 1'b0;
          rsp_err      <= 1'b1;
        end
      end
      if (state == EXEC) begin
        rsp_y        <= alu_y;
        rsp_zero     <= alu_zero;
        rsp_negative <= alu_negative;
        rsp_carry    <= alu_carry;
        rsp_err      <= 1'b0;
        acc          <= alu_y;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a behavioural ALU model driving the alu_* inputs.
module tb_alu_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_use_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [7:0] alu_y;
  logic       alu_zero;
  logic       alu_negative;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic       rsp_zero;
  logic       rsp_negative;
  logic       rsp_carry;
  logic       rsp_err;
  logic [7:0] acc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_cmd_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_use_acc  (cmd_use_acc),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_y        (alu_y),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_carry    (alu_carry),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_y        (rsp_y),
    .rsp_zero     (rsp_zero),
    .rsp_negative (rsp_negative),
    .rsp_carry    (rsp_carry),
    .rsp_err      (rsp_err),
    .acc          (acc)
  );

  // Combinational ALU responder
  logic [8:0] alu_wide;
  always_comb begin
    alu_wide     = '0;
    alu_negative = 1'b0;
    case (alu_ctrl)
      3'b000:  alu_wide = {1'b0, alu_a & alu_b};
      3'b001:  alu_wide = {1'b0, alu_a | alu_b};
      3'b010:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      default: alu_wide = '0;
    endcase
    alu_y     = alu_wide[7:0];
    alu_zero  = (alu_wide[7:0] == 8'h00);
    alu_carry = alu_wide[8];
    alu_negative = (alu_ctrl == 3'b110) ? (alu_a < alu_b) : alu_wide[7];
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
    logic [7:0] y;
    logic       z;
    logic       n;
    logic       c;
    logic       err;
    logic [7:0] acc;
    logic [7:0] alu_a;
    logic [2:0] ctrl;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int n;
    n = 0;
    while (!cmd_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_op      = v.op;
    cmd_a       = v.a;
    cmd_b       = v.b;
    cmd_use_acc = v.use_acc;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), v.err ? 32'd1 : 32'd2);
    chk("rsp_y", 32'(rsp_y), 32'(v.y));
    chk("flags_znc", {29'd0, rsp_zero, rsp_negative, rsp_carry}, {29'd0, v.z, v.n, v.c});
    chk("rsp_err", 32'(rsp_err), 32'(v.err));
    chk("acc", 32'(acc), 32'(v.acc));
    chk("alu_a", 32'(alu_a), 32'(v.alu_a));
    chk("alu_ctrl", 32'(alu_ctrl), 32'(v.ctrl));
    @(negedge clk);
    chk("idle_after_rsp", {30'd0, cmd_ready, rsp_valid}, 32'b10);
  endtask

  initial begin
    //           op      a      b   ua   y     z    n    c    err  acc   alu_a ctrl
    vecs[0] = '{3'b010, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'hF0, 3'b010};
    vecs[1] = '{3'b010, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08, 8'h05, 3'b010};
    vecs[2] = '{3'b110, 8'h77, 8'h08, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 3'b110};
    vecs[3] = '{3'b011, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h08, 3'b110};
    vecs[4] = '{3'b001, 8'h81, 8'h02, 1'b0, 8'h83, 1'b0, 1'b1, 1'b0, 1'b0, 8'h83, 8'h81, 3'b001};
    vecs[5] = '{3'b110, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFE, 8'h03, 3'b110};
    vecs[6] = '{3'b000, 8'h00, 8'h0F, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0E, 8'hFE, 3'b000};
    vecs[7] = '{3'b111, 8'h55, 8'h66, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0E, 8'hFE, 3'b000};
    vecs[8] = '{3'b010, 8'h00, 8'hF2, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h0E, 3'b010};

    // Reset held with a command pending
    rst_n       = 1'b0;
    cmd_valid   = 1'b1;
    cmd_op      = 3'b010;
    cmd_a       = 8'h10;
    cmd_b       = 8'h10;
    cmd_use_acc = 1'b0;
    rsp_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_outs", {rsp_valid, rsp_err, rsp_zero, rsp_negative, rsp_carry, rsp_y, acc, alu_a},
          32'd0);
      chk("rst_ctrl_b", {21'd0, alu_ctrl, alu_b}, 32'd0);
    end
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {30'd0, cmd_ready, rsp_valid}, 32'b10);

    for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

    // Backpressure with a competing command held during RESP
    rsp_ready = 1'b0;
    run_bp();

    // Reset in the EXEC cycle drops the command
    cmd_valid = 1'b1;
    cmd_op    = 3'b010;
    cmd_a     = 8'h01;
    cmd_b     = 8'h01;
    cmd_use_acc = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("exec_not_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("exec_rst_valid", 32'(rsp_valid), 32'd0);
    chk("exec_rst_acc", 32'(acc), 32'd0);
    chk("exec_rst_alu_a", 32'(alu_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("exec_rst_idle", {30'd0, cmd_ready, rsp_valid}, 32'b10);
    run_cmd('{3'b010, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h01, 3'b010});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic run_bp();
    int n;
    cmd_valid   = 1'b1;
    cmd_op      = 3'b000;
    cmd_a       = 8'hCC;
    cmd_b       = 8'h0F;
    cmd_use_acc = 1'b0;
    @(negedge clk);
    // Second command stays asserted and must wait for the handshake
    cmd_op = 3'b001;
    cmd_a  = 8'h11;
    cmd_b  = 8'h22;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_y", 32'(rsp_y), 32'h0C);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
      chk("bp_alu_ctrl", 32'(alu_ctrl), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", {30'd0, cmd_ready, rsp_valid}, 32'b10);
    chk("bp_acc", 32'(acc), 32'h0C);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_second_exec", {29'd0, cmd_ready, rsp_valid, 1'b0}, 32'd0);
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("bp_second_lat", 32'(n), 32'd1);
    chk("bp_second_y", 32'(rsp_y), 32'h33);
    chk("bp_second_acc", 32'(acc), 32'h33);
    @(negedge clk);
  endtask

endmodule
